uart_serial_rx: RTL
===================

// Module: uart_serial_rx
// PURPOSE
// - Asynchronous serial receiver; link partner that decodes frames driven on the uart o_tx line.
// - Recovers character, parity and stop status from a 16x-oversampled line.
// - Presents each frame on a valid/ready handshake for the bench or a peer block.
// - Paired with the uart block in dut_top-level benches; also reusable as RTL.
// PARAMETERS
// - DIV_W    12  width of baud divisor input (UBRR-style)
// - SYNC_STG 2   synchronizer flops on i_rx (>=2)
// PORTS
// - i_clk        in   1      system clock; single clock domain
// - i_rst_n      in   1      asynchronous, active-low reset
// - i_rx         in   1      serial line; idle high; asynchronous to i_clk
// - i_ubrr       in   DIV_W  16x tick every (i_ubrr+1) clocks; baud = f/(16*(i_ubrr+1))
// - i_char_size  in   3      0..3 = 5..8 bits; 7 = 9 bits; 4..6 treated as 8
// - i_parity     in   2      00 none, 10 even, 11 odd, 01 reserved = none
// - i_rx_en      in   1      receiver enable; 0 forces IDLE, flags untouched
// - i_ready      in   1      consumer accepts o_data when o_valid & i_ready
// - o_data       out  9      received character, LSB-aligned, upper bits 0
// - o_valid      out  1      character available; held until accepted
// - o_frame_err  out  1      stop bit sampled 0 for the character in o_data
// - o_parity_err out  1      parity mismatch for the character in o_data
// - o_overrun    out  1      a frame completed and was dropped while o_valid & !i_ready
// - o_busy       out  1      state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; synchronizer flops preset to 1 (line idle).
// - Tick: divider counts 0..i_ubrr and pulses tick at terminal; restarts at 0 on start edge.
// - Sample: 4-bit sub-counter per bit; value = majority of samples 7,8,9.
// - Config: i_char_size and i_parity latched at start edge; mid-frame changes ignored.
// - IDLE: synced rx 1->0 with i_rx_en=1 -> START; divider and sub-counter cleared.
// - START: majority 1 at sample 9 = false start -> IDLE, no flags; else at sample 15 -> DATA.
// - DATA: LSB first; bit count = latched size; after last bit -> PARITY if enabled, else STOP.
// - PARITY: even = XOR(data, p) must be 0; odd = XOR must be 1; mismatch sets parity flag.
// - STOP: evaluated at sample 9; 1 = OK, 0 = frame error; second stop bit never checked.
// - STOP exit: -> IDLE after sample 9, so a new start edge is accepted within half a bit.
// - Result: o_data, o_frame_err and o_parity_err load 1 clock after STOP sample 9;
//   o_valid set in the same cycle.
// - Handshake: o_valid & i_ready -> o_valid clears next clock; error flags clear with it.
// - Simultaneous accept and new result in one cycle -> new result loads, o_valid stays 1,
//   no overrun.
// - Overrun: result arrives with o_valid=1 & !i_ready -> new frame dropped, o_overrun=1,
//   held data unchanged.
// - Overrun clear: o_overrun clears on the next accept.
// - Frame error with line held low (break): returns to IDLE; a new start needs a 0->1->0 edge.
// - i_rx_en 0 mid-frame: -> IDLE next clock; partial frame discarded; o_valid and data kept.
// - Reset mid-frame: asynchronous abort to reset values; no partial result ever appears.
// - i_ubrr=0: tick every clock (16 clocks per bit) is legal.
// STRUCTURE
// - uart_pkg: rx_state_e {IDLE,START,DATA,PARITY,STOP}; CHAR_* size codes; PAR_* codes;
//   MID_SAMPLE=8.
// - Sub-module uart_baud_tick: DIV_W down-counter, sync clear, tick pulse; reusable by TX.
// - Top: synchronizer, FSM, shift register, parity accumulator, output holding register.
// TESTING
// - 8N1, ubrr=0, send 0xA5 -> o_valid after 1 start + 8 data + stop sample 9; o_data=0x0A5,
//   no errors.
// - 8E1, send 0x03 with parity bit 1 -> o_parity_err=1; with parity 0 -> clean, o_data=0x003.
// - 9O1, send 0x1FF with parity 0 -> clean, o_data=0x1FF; 5N1 send 0x15 -> o_data=0x015.
// - Stop bit driven 0 on 0x55 -> o_frame_err=1, o_data=0x055; next frame 0x11 clean.
// - Hold i_ready=0; send 0x01, 0x02 -> o_data=0x001, o_overrun=1.
//   Accept -> o_valid=0, o_overrun=0.
// - 3-sample low glitch -> no o_valid, o_busy back to 0; async reset mid-DATA -> all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame codes,
// sample-point position and a character-size decoder.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  // i_char_size codes; 4..6 decode as 8 bits
  localparam logic [2:0] CHAR_5 = 3'd0;
  localparam logic [2:0] CHAR_6 = 3'd1;
  localparam logic [2:0] CHAR_7 = 3'd2;
  localparam logic [2:0] CHAR_8 = 3'd3;
  localparam logic [2:0] CHAR_9 = 3'd7;

  // i_parity codes; bit 1 enables, bit 0 selects odd
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_RSVD = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_ODD  = 2'b11;

  // centre of the 16 sub-samples; majority uses MID-1, MID, MID+1
  localparam logic [3:0] MID_SAMPLE = 4'd8;

  // number of data bits carried by a frame
  function automatic logic [3:0] char_bits(input logic [2:0] cs);
    case (cs)
      CHAR_5:  char_bits = 4'd5;
      CHAR_6:  char_bits = 4'd6;
      CHAR_7:  char_bits = 4'd7;
      CHAR_9:  char_bits = 4'd9;
      default: char_bits = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: one-cycle tick every (i_ubrr+1) clocks.
// A synchronous clear realigns the phase to a start edge.
module uart_baud_tick #(
  parameter int DIV_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_ubrr,
  input  logic             i_clr,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt;

  // tick when the down-counter hits zero; i_ubrr=0 ticks every clock
  assign o_tick = (cnt == '0);

  // reload on clear or terminal count, otherwise count down
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                cnt <= '0;
    else if (i_clr || o_tick)    cnt <= i_ubrr;
    else                         cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/uart_serial_rx.sv
// Asynchronous serial receiver: synchronizes the line, oversamples each bit
// 16x with a 3-sample majority vote, and presents characters plus frame,
// parity and overrun status on a valid/ready handshake.
module uart_serial_rx
  import uart_pkg::*;
#(
  parameter int DIV_W    = 12,
  parameter int SYNC_STG = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx,
  input  logic [DIV_W-1:0] i_ubrr,
  input  logic [2:0]       i_char_size,
  input  logic [1:0]       i_parity,
  input  logic             i_rx_en,
  input  logic             i_ready,
  output logic [8:0]       o_data,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_parity_err,
  output logic             o_overrun,
  output logic             o_busy
);

  rx_state_e           state;
  logic [SYNC_STG-1:0] sync_q;
  logic                rx_s, rx_prev;
  logic                tick, start_edge, maj, at_mid, at_end;
  logic [3:0]          sub, bit_cnt, nbits;
  logic [8:0]          shreg;
  logic                s7, s8, par_acc, par_en, par_odd;
  logic                done, done_fe, done_pe;

  assign rx_s       = sync_q[SYNC_STG-1];
  assign start_edge = i_rx_en && rx_prev && !rx_s;
  assign maj        = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign at_mid     = (sub == MID_SAMPLE + 4'd1);
  assign at_end     = (sub == 4'd15);
  assign o_busy     = (state != IDLE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_ubrr  (i_ubrr),
    .i_clr   (state == IDLE && start_edge),
    .o_tick  (tick)
  );

  // line synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STG-2:0], i_rx};
      rx_prev <= rx_s;
    end
  end

  // frame FSM: bit timing, data capture, parity accumulation, stop check
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      sub     <= '0;
      bit_cnt <= '0;
      nbits   <= 4'd8;
      shreg   <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      par_acc <= 1'b0;
      par_en  <= 1'b0;
      par_odd <= 1'b0;
      done    <= 1'b0;
      done_fe <= 1'b0;
      done_pe <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!i_rx_en) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        if (start_edge) begin
          state   <= START;
          sub     <= '0;
          bit_cnt <= '0;
          shreg   <= '0;
          par_acc <= 1'b0;
          nbits   <= char_bits(i_char_size);
          par_en  <= i_parity[1];
          par_odd <= i_parity[0];
        end
      end else if (tick) begin
        sub <= sub + 4'd1;
        if (sub == MID_SAMPLE - 4'd1) s7 <= rx_s;
        if (sub == MID_SAMPLE)        s8 <= rx_s;
        case (state)
          START: begin
            if (at_mid && maj) state <= IDLE;
            else if (at_end)   state <= DATA;
          end
          DATA: begin
            if (at_mid) begin
              shreg[bit_cnt] <= maj;
              par_acc        <= par_acc ^ maj;
            end
            if (at_end) begin
              if (bit_cnt == nbits - 4'd1) state <= par_en ? PARITY : STOP;
              else                         bit_cnt <= bit_cnt + 4'd1;
            end
          end
          PARITY: begin
            if (at_mid) par_acc <= par_acc ^ maj;
            if (at_end) state   <= STOP;
          end
          STOP: begin
            if (at_mid) begin
              state   <= IDLE;
              done    <= 1'b1;
              done_fe <= ~maj;
              done_pe <= par_en & (par_acc ^ par_odd);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // holding register and handshake; a result arriving while full is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (done) begin
      if (o_valid && !i_ready) begin
        o_overrun <= 1'b1;
      end else begin
        o_data       <= shreg;
        o_frame_err  <= done_fe;
        o_parity_err <= done_pe;
        o_valid      <= 1'b1;
        if (o_valid) o_overrun <= 1'b0;
      end
    end else if (o_valid && i_ready) begin
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end
  end

endmodule
